// File: rtl/conv_stream_feeder_pkg.sv
// Shared sizing constants and FSM encoding for the conv unit stream feeder.
// Tile geometry is derived so that every kernel position up to MAX_KERNEL fits a full window.
package conv_stream_feeder_pkg;
    localparam int DATA_WIDTH        = 16;
    localparam int PARA_X            = 3;
    localparam int PARA_Y            = 3;
    localparam int MAX_KERNEL        = 5;
    localparam int KERNEL_SIZE_WIDTH = 3;

    localparam int TILE_W       = PARA_X + MAX_KERNEL - 1;
    localparam int TILE_H       = PARA_Y + MAX_KERNEL - 1;
    localparam int TILE_DEPTH   = TILE_W * TILE_H;
    localparam int WT_DEPTH     = MAX_KERNEL * MAX_KERNEL;
    localparam int TILE_AW      = $clog2(TILE_DEPTH);
    localparam int WT_AW        = $clog2(WT_DEPTH);
    localparam int WINDOW_WIDTH = PARA_X * PARA_Y * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    function automatic logic [TILE_AW-1:0] tile_addr(input int row, input int col);
        return TILE_AW'(row * TILE_W + col);
    endfunction
endpackage

// File: rtl/conv_tile_buffer.sv
// Input tile register array with one write port and a combinational PARA_X x PARA_Y window read.
// A write landing on a window pixel in the same cycle is forwarded so the captured window sees it.
module conv_tile_buffer
    import conv_stream_feeder_pkg::*;
(
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [TILE_AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [KERNEL_SIZE_WIDTH-1:0] rd_kx,
    input  logic [KERNEL_SIZE_WIDTH-1:0] rd_ky,
    output logic [WINDOW_WIDTH-1:0]      window
);
    logic [DATA_WIDTH-1:0] tile [TILE_DEPTH];
    logic [TILE_AW-1:0]    idx;

    always_ff @(posedge clk) begin
        if (wr_en && wr_addr < TILE_AW'(TILE_DEPTH)) begin
            tile[wr_addr] <= wr_data;
        end
    end

    // Lane y*PARA_X+x carries tile[ky+y][kx+x]
    always_comb begin
        window = '0;
        idx    = '0;
        for (int y = 0; y < PARA_Y; y++) begin
            for (int x = 0; x < PARA_X; x++) begin
                idx = tile_addr(int'(rd_ky) + y, int'(rd_kx) + x);
                window[(y*PARA_X + x)*DATA_WIDTH +: DATA_WIDTH] =
                    (wr_en && wr_addr == idx) ? wr_data : tile[idx];
            end
        end
    end
endmodule

// File: rtl/conv_stream_feeder.sv
// Streams one window plus matching weight per cycle into the parallel FP16 conv unit,
// then holds it running until result_ready and issues its end-of-job reset pulse.
module conv_stream_feeder
    import conv_stream_feeder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tile_wr_en,
    input  logic [TILE_AW-1:0]           tile_wr_addr,
    input  logic [DATA_WIDTH-1:0]        tile_wr_data,
    input  logic                         wt_wr_en,
    input  logic [WT_AW-1:0]             wt_wr_addr,
    input  logic [DATA_WIDTH-1:0]        wt_wr_data,
    input  logic                         start,
    input  logic [KERNEL_SIZE_WIDTH-1:0] kernel_size,
    input  logic                         result_ready,
    output logic                         conv_rst_n,
    output logic [WINDOW_WIDTH-1:0]      input_data,
    output logic [DATA_WIDTH-1:0]        weight,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    logic [1:0]                   state;
    logic [KERNEL_SIZE_WIDTH-1:0] k_reg, kx, ky, rd_kx, rd_ky;
    logic [DATA_WIDTH-1:0]        wt_mem [WT_DEPTH];
    logic [WINDOW_WIDTH-1:0]      window;
    logic [DATA_WIDTH-1:0]        wt_next;
    logic [WT_AW-1:0]             wt_idx;
    logic                         idle, tile_we, wt_we, k_legal, last_step, row_end;

    assign idle      = (state == ST_IDLE);
    assign tile_we   = tile_wr_en && idle;
    assign wt_we     = wt_wr_en && idle && (wt_wr_addr < WT_AW'(WT_DEPTH));
    assign k_legal   = (kernel_size != '0) && (kernel_size <= KERNEL_SIZE_WIDTH'(MAX_KERNEL));
    assign row_end   = (kx == k_reg - KERNEL_SIZE_WIDTH'(1));
    assign last_step = row_end && (ky == k_reg - KERNEL_SIZE_WIDTH'(1));

    // Read position is the step about to be registered: (0,0) on start, else the next step
    always_comb begin
        rd_kx = '0;
        rd_ky = '0;
        if (state == ST_STREAM) begin
            if (row_end) begin
                rd_ky = ky + KERNEL_SIZE_WIDTH'(1);
            end else begin
                rd_kx = kx + KERNEL_SIZE_WIDTH'(1);
                rd_ky = ky;
            end
        end
    end

    assign wt_idx  = WT_AW'(rd_ky) * WT_AW'(k_reg) + WT_AW'(rd_kx);
    assign wt_next = (wt_we && wt_wr_addr == wt_idx) ? wt_wr_data : wt_mem[wt_idx];

    always_ff @(posedge clk) begin
        if (wt_we) begin
            wt_mem[wt_wr_addr] <= wt_wr_data;
        end
    end

    conv_tile_buffer u_tile_buffer (
        .clk     (clk),
        .wr_en   (tile_we),
        .wr_addr (tile_wr_addr),
        .wr_data (tile_wr_data),
        .rd_kx   (rd_kx),
        .rd_ky   (rd_ky),
        .window  (window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            k_reg      <= '0;
            kx         <= '0;
            ky         <= '0;
            conv_rst_n <= 1'b0;
            input_data <= '0;
            weight     <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (k_legal) begin
                            state      <= ST_STREAM;
                            k_reg      <= kernel_size;
                            kx         <= '0;
                            ky         <= '0;
                            input_data <= window;
                            weight     <= wt_next;
                            out_valid  <= 1'b1;
                            busy       <= 1'b1;
                            conv_rst_n <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (last_step) begin
                        state     <= ST_WAIT;
                        out_valid <= 1'b0;
                    end else begin
                        kx         <= rd_kx;
                        ky         <= rd_ky;
                        input_data <= window;
                        weight     <= wt_next;
                    end
                end
                ST_WAIT: begin
                    if (result_ready) begin
                        state      <= ST_FLUSH;
                        conv_rst_n <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed-plus-random bench for conv_stream_feeder; expected windows and weights come from
// a plain array model of the tile and kernel, indexed by step number.
module tb_conv_stream_feeder;
    import conv_stream_feeder_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         tile_wr_en = 1'b0;
    logic [TILE_AW-1:0]           tile_wr_addr = '0;
    logic [DATA_WIDTH-1:0]        tile_wr_data = '0;
    logic                         wt_wr_en = 1'b0;
    logic [WT_AW-1:0]             wt_wr_addr = '0;
    logic [DATA_WIDTH-1:0]        wt_wr_data = '0;
    logic                         start = 1'b0;
    logic [KERNEL_SIZE_WIDTH-1:0] kernel_size = '0;
    logic                         result_ready = 1'b0;
    logic                         conv_rst_n;
    logic [WINDOW_WIDTH-1:0]      input_data;
    logic [DATA_WIDTH-1:0]        weight;
    logic                         out_valid, busy, done, err;

    logic [DATA_WIDTH-1:0] tile_m [TILE_H][TILE_W];
    logic [DATA_WIDTH-1:0] wt_m [WT_DEPTH];
    int asserts_evaluated = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_stream_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .tile_wr_en   (tile_wr_en),
        .tile_wr_addr (tile_wr_addr),
        .tile_wr_data (tile_wr_data),
        .wt_wr_en     (wt_wr_en),
        .wt_wr_addr   (wt_wr_addr),
        .wt_wr_data   (wt_wr_data),
        .start        (start),
        .kernel_size  (kernel_size),
        .result_ready (result_ready),
        .conv_rst_n   (conv_rst_n),
        .input_data   (input_data),
        .weight       (weight),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic checkOutput(input string tag, input logic [WINDOW_WIDTH-1:0] observed,
                               input logic [WINDOW_WIDTH-1:0] expected);
        asserts_evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic t_en, input int t_addr, input logic [15:0] t_data,
                                 input logic w_en, input int w_addr, input logic [15:0] w_data,
                                 input logic st, input int ks, input logic rr);
        tile_wr_en   = t_en;
        tile_wr_addr = TILE_AW'(t_addr);
        tile_wr_data = t_data;
        wt_wr_en     = w_en;
        wt_wr_addr   = WT_AW'(w_addr);
        wt_wr_data   = w_data;
        start        = st;
        kernel_size  = KERNEL_SIZE_WIDTH'(ks);
        result_ready = rr;
    endtask

    // Step s of a k-kernel job sits at kx = s % k, ky = s / k
    function automatic logic [WINDOW_WIDTH-1:0] modelWindow(input int k, input int s);
        logic [WINDOW_WIDTH-1:0] w;
        w = '0;
        for (int y = 0; y < PARA_Y; y++)
            for (int x = 0; x < PARA_X; x++)
                w[(y*PARA_X + x)*DATA_WIDTH +: DATA_WIDTH] = tile_m[s/k + y][s%k + x];
        return w;
    endfunction

    task automatic loadBuffers(input bit random_data);
        logic [15:0] d;
        logic [15:0] plan_wt [9];
        plan_wt = '{16'h3c00, 16'h4000, 16'h4200, 16'h3c00, 16'h4400,
                    16'h3c00, 16'h0000, 16'h4000, 16'h3c00};
        for (int r = 0; r < TILE_H; r++) begin
            for (int c = 0; c < TILE_W; c++) begin
                d = random_data ? 16'($urandom) : 16'(r*16 + c);
                @(posedge clk); #1;
                applyStimulus(1'b1, r*TILE_W + c, d, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
                tile_m[r][c] = d;
            end
        end
        for (int i = 0; i < WT_DEPTH; i++) begin
            d = (!random_data && i < 9) ? plan_wt[i] : 16'($urandom);
            @(posedge clk); #1;
            applyStimulus(1'b0, 0, 16'h0, 1'b1, i, d, 1'b0, 0, 1'b0);
            wt_m[i] = d;
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic rejectStart(input int ks);
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, ks, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("reject k%0d err", ks), err, 1'b1);
        checkOutput($sformatf("reject k%0d busy", ks), busy, 1'b0);
        checkOutput($sformatf("reject k%0d out_valid", ks), out_valid, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("reject k%0d err drop", ks), err, 1'b0);
    endtask

    // abort_step >= 0 asserts rst right after that step is checked
    task automatic runJob(input int k, input int rr_delay, input bit wr_in_stream,
                          input bit rr_in_stream, input bit wr_at_start, input int abort_step);
        int n;
        int r, c;
        logic [15:0] dt, dw;
        n = k * k;
        @(posedge clk); #1;
        if (wr_at_start) begin
            r = $urandom_range(0, 2);
            c = $urandom_range(0, 2);
            dt = 16'($urandom);
            dw = 16'($urandom);
            applyStimulus(1'b1, r*TILE_W + c, dt, 1'b1, 0, dw, 1'b1, k, 1'b0);
            tile_m[r][c] = dt;
            wt_m[0] = dw;
        end else begin
            applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, k, 1'b0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, rr_in_stream);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            checkOutput($sformatf("k%0d step%0d out_valid", k, s), out_valid, 1'b1);
            checkOutput($sformatf("k%0d step%0d busy", k, s), busy, 1'b1);
            checkOutput($sformatf("k%0d step%0d conv_rst_n", k, s), conv_rst_n, 1'b1);
            checkOutput($sformatf("k%0d step%0d done", k, s), done, 1'b0);
            checkOutput($sformatf("k%0d step%0d window", k, s), input_data, modelWindow(k, s));
            checkOutput($sformatf("k%0d step%0d weight", k, s), weight, wt_m[s]);
            if (s == abort_step) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("abort out_valid", out_valid, 1'b0);
                checkOutput("abort busy", busy, 1'b0);
                checkOutput("abort conv_rst_n", conv_rst_n, 1'b0);
                checkOutput("abort window", input_data, '0);
                applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput($sformatf("abort cycle%0d done", i), done, 1'b0);
                end
                rst = 1'b0;
                return;
            end
            if (wr_in_stream && s == 1)
                applyStimulus(1'b1, $urandom_range(0, TILE_DEPTH-1), 16'hFFFF,
                              1'b1, $urandom_range(0, WT_DEPTH-1), 16'hFFFF, 1'b0, 0, rr_in_stream);
            if (s == n-1)
                applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
        end
        for (int d = 0; d < rr_delay; d++) begin
            @(negedge clk);
            checkOutput($sformatf("k%0d wait%0d out_valid", k, d), out_valid, 1'b0);
            checkOutput($sformatf("k%0d wait%0d conv_rst_n", k, d), conv_rst_n, 1'b1);
            checkOutput($sformatf("k%0d wait%0d busy", k, d), busy, 1'b1);
            checkOutput($sformatf("k%0d wait%0d done", k, d), done, 1'b0);
            checkOutput($sformatf("k%0d wait%0d err", k, d), err, 1'b0);
            checkOutput($sformatf("k%0d wait%0d window", k, d), input_data, modelWindow(k, n-1));
            checkOutput($sformatf("k%0d wait%0d weight", k, d), weight, wt_m[n-1]);
            if (d == 0 && rr_delay > 1)
                applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b1, 0, 1'b0);
            if (d == rr_delay-1)
                applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b1);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("k%0d flush done", k), done, 1'b1);
        checkOutput($sformatf("k%0d flush conv_rst_n", k), conv_rst_n, 1'b0);
        checkOutput($sformatf("k%0d flush busy", k), busy, 1'b1);
        checkOutput($sformatf("k%0d flush out_valid", k), out_valid, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("k%0d idle done", k), done, 1'b0);
        checkOutput($sformatf("k%0d idle busy", k), busy, 1'b0);
        checkOutput($sformatf("k%0d idle conv_rst_n", k), conv_rst_n, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset conv_rst_n", conv_rst_n, 1'b0);
        checkOutput("reset input_data", input_data, '0);
        checkOutput("reset weight", weight, '0);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset err", err, 1'b0);
        rst = 1'b0;

        loadBuffers(1'b0);
        runJob(3, 6, 1'b0, 1'b1, 1'b0, -1);
        rejectStart(0);
        rejectStart(6);
        rejectStart(7);
        runJob(3, 2, 1'b1, 1'b0, 1'b0, -1);
        runJob(3, 3, 1'b0, 1'b0, 1'b0, -1);
        runJob(5, 2, 1'b0, 1'b0, 1'b0, -1);

        loadBuffers(1'b1);
        runJob(5, 3, 1'b0, 1'b0, 1'b1, -1);
        runJob(1, 2, 1'b0, 1'b0, 1'b0, -1);
        runJob($urandom_range(2, 4), 4, 1'b0, 1'b0, 1'b1, -1);
        runJob(3, 2, 1'b0, 1'b0, 1'b0, 4);
        runJob($urandom_range(1, 5), 2, 1'b0, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_evaluated, failures);
        $finish;
    end
endmodule
